// File: rtl/calc1_port_responder_pkg.sv
// Shared encodings for the calc1 request/response protocol.
// Commands, response codes and the responder's state constants live here.
package calc1_pkg;

    typedef logic [3:0] cmd_t;
    typedef logic [1:0] resp_t;
    typedef logic [1:0] state_t;

    localparam cmd_t CMD_NOP = 4'd0;
    localparam cmd_t CMD_ADD = 4'd1;
    localparam cmd_t CMD_SUB = 4'd2;
    localparam cmd_t CMD_SHL = 4'd5;
    localparam cmd_t CMD_SHR = 4'd6;

    localparam resp_t RESP_NONE     = 2'd0;
    localparam resp_t RESP_OK       = 2'd1;
    localparam resp_t RESP_ERR      = 2'd2;
    localparam resp_t RESP_INTERNAL = 2'd3;

    localparam state_t IDLE    = 2'd0;
    localparam state_t GET_OP2 = 2'd1;
    localparam state_t EXEC    = 2'd2;
    localparam state_t RESP    = 2'd3;

endpackage

// File: rtl/calc1_port_responder_if.sv
// One calc1 requester channel: command/operand in, response/result/busy out.
// Data buses are numbered with bit 0 as the MSB.
interface calc1_port_responder_if
    import calc1_pkg::*;
#(
    parameter int DATA_W = 32
);

    cmd_t              req_cmd_in;
    logic [0:DATA_W-1] req_data_in;
    resp_t             out_resp;
    logic [0:DATA_W-1] out_data;
    logic              busy;

    modport master (
        output req_cmd_in,
        output req_data_in,
        input  out_resp,
        input  out_data,
        input  busy
    );

    modport slave (
        input  req_cmd_in,
        input  req_data_in,
        output out_resp,
        output out_data,
        output busy
    );

endinterface

// File: rtl/calc1_port_responder_alu.sv
// Combinational calc1 datapath: add/sub/shift with an error flag for
// carry-out, borrow and unknown commands.
module calc1_alu
    import calc1_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  cmd_t              cmd,
    input  logic [0:DATA_W-1] op1,
    input  logic [0:DATA_W-1] op2,
    output logic [0:DATA_W-1] result,
    output logic              err
);

    logic [0:DATA_W] sum;
    logic [4:0]      shamt;

    always_comb begin
        result = '0;
        err    = 1'b0;
        sum    = {1'b0, op1} + {1'b0, op2};
        // Shift amount is the five least-significant bits, which sit at the high indices.
        shamt  = op2[DATA_W-5:DATA_W-1];
        case (cmd)
            CMD_ADD: begin
                if (sum[0]) err = 1'b1;
                else        result = sum[1:DATA_W];
            end
            CMD_SUB: begin
                if (op2 > op1) err = 1'b1;
                else           result = op1 - op2;
            end
            CMD_SHL: result = op1 << shamt;
            CMD_SHR: result = op1 >> shamt;
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/calc1_port_responder.sv
// Single-channel calc1 responder: captures cmd+op1, then op2, waits LATENCY
// cycles in total and presents a one-cycle response with the result.
module calc1_port_responder
    import calc1_pkg::*;
#(
    parameter int LATENCY = 3,
    parameter int DATA_W  = 32
) (
    input logic                          c_clk,
    input logic                          reset,
    calc1_port_responder_if.slave        bus
);

    state_t            state;
    logic [3:0]        cnt;
    cmd_t              cmd_q;
    logic [0:DATA_W-1] op1_q;
    logic [0:DATA_W-1] op2_q;
    resp_t             resp_q;
    logic [0:DATA_W-1] data_q;

    logic [0:DATA_W-1] alu_op2;
    logic [0:DATA_W-1] alu_result;
    logic              alu_err;
    logic              enter_resp;

    // With LATENCY of 1 the result is formed in the op2 cycle, so op2 comes straight off the bus.
    assign alu_op2    = (state == GET_OP2) ? bus.req_data_in : op2_q;
    assign enter_resp = ((state == GET_OP2) && (LATENCY == 1)) ||
                        ((state == EXEC) && (cnt == 4'd1));

    calc1_alu #(.DATA_W(DATA_W)) u_alu (
        .cmd    (cmd_q),
        .op1    (op1_q),
        .op2    (alu_op2),
        .result (alu_result),
        .err    (alu_err)
    );

    always_ff @(posedge c_clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            cmd_q  <= CMD_NOP;
            op1_q  <= '0;
            op2_q  <= '0;
            resp_q <= RESP_NONE;
            data_q <= '0;
        end else begin
            resp_q <= RESP_NONE;
            data_q <= '0;
            case (state)
                IDLE: begin
                    if (bus.req_cmd_in != CMD_NOP) begin
                        cmd_q <= bus.req_cmd_in;
                        op1_q <= bus.req_data_in;
                        state <= GET_OP2;
                    end
                end
                GET_OP2: begin
                    op2_q <= bus.req_data_in;
                    cnt   <= 4'(LATENCY - 1);
                    state <= (LATENCY == 1) ? RESP : EXEC;
                end
                EXEC: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (enter_resp) begin
                resp_q <= alu_err ? RESP_ERR : RESP_OK;
                data_q <= alu_err ? '0 : alu_result;
            end
        end
    end

    assign bus.out_resp = resp_q;
    assign bus.out_data = data_q;
    assign bus.busy     = (state != IDLE);

endmodule
